// File: rtl/hex_display_pkg.sv
// Shared types and helpers for the binary-to-BCD / seven-segment display path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hex_display_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam int BCD_W      = 4;
   localparam int MAX_DIGITS = 16;
   localparam int MASK_IN_W  = BCD_W * MAX_DIGITS;

   // True when DIGITS decimal digits can hold every IN_W-bit unsigned value.
   function automatic bit digits_fit(input int in_w, input int n_digits);
      logic [127:0] dec_range;
      logic [127:0] bin_max;
      dec_range = 128'd1;
      for (int i = 0; i < n_digits; i++) dec_range = dec_range * 128'd10;
      bin_max = (128'd1 << in_w) - 128'd1;
      return dec_range > bin_max;
   endfunction

   // Leading-zero flag for digit idx: set when idx and every more-significant
   // digit are zero. The ones digit is never blanked so a zero still shows.
   function automatic logic blank_digit(input logic [MASK_IN_W-1:0] bcd, input int idx);
      logic z;
      z = (idx != 0);
      for (int i = 0; i < MAX_DIGITS; i++) begin
         if (i >= idx && bcd[i*BCD_W +: BCD_W] != '0) z = 1'b0;
      end
      return z;
   endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: adds 3 to a BCD digit that is 5 or more.
// Latency: combinational.
// Backpressure: none.
module bcd_add3
   import hex_display_pkg::*;
(
   input  logic [BCD_W-1:0] nib,
   output logic [BCD_W-1:0] adj
);

   // Corrected digit; valid inputs are 0-9 so the result never wraps.
   always_comb begin
      adj = nib;
      if (nib >= 4'd5) adj = nib + 4'd3;
   end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) with leading-zero blank mask.
// Latency: done and digits/blank appear IN_W edges after the accepting edge; one conversion per IN_W+1 cycles.
// Backpressure: start is dropped while converting; a start held through the done cycle chains the next conversion.
module bin_to_bcd_seq
   import hex_display_pkg::*;
#(
   parameter int IN_W   = 16,
   parameter int DIGITS = 5
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [IN_W-1:0]         bin_in,
   output logic                    busy,
   output logic                    done,
   output logic [BCD_W*DIGITS-1:0] digits,
   output logic [DIGITS-1:0]       blank
);

   localparam int BCD_TOT = BCD_W * DIGITS;
   localparam int CNT_W   = $clog2(IN_W + 1);
   localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

   if (!digits_fit(IN_W, DIGITS)) begin : g_bad_digits
      $error("bin_to_bcd_seq: DIGITS too small for IN_W");
   end
   if (DIGITS > MAX_DIGITS || IN_W < 2) begin : g_bad_size
      $error("bin_to_bcd_seq: unsupported IN_W/DIGITS");
   end

   state_t               state, state_nxt;
   logic [IN_W-1:0]      sh_bin;
   logic [BCD_TOT-1:0]   bcd;
   logic [BCD_TOT-1:0]   bcd_adj;
   logic [BCD_TOT-1:0]   bcd_shift;
   logic [CNT_W-1:0]     cnt;
   logic [MASK_IN_W-1:0] bcd_ext;
   logic [DIGITS-1:0]    blank_nxt;
   logic                 load;
   logic                 last;

   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .nib (bcd[g*BCD_W +: BCD_W]),
         .adj (bcd_adj[g*BCD_W +: BCD_W])
      );
   end

   // Accept a start in IDLE, or in DONE so a held start runs back-to-back.
   always_comb begin
      load      = start && (state == IDLE || state == DONE);
      last      = (state == SHIFT) && (cnt == CNT_W'(1));
      bcd_shift = BCD_TOT'({bcd_adj, sh_bin[IN_W-1]});
      bcd_ext   = MASK_IN_W'(bcd_shift);
      blank_nxt = '0;
      for (int i = 0; i < DIGITS; i++) blank_nxt[i] = blank_digit(bcd_ext, i);
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (last) state_nxt = DONE;
         DONE:    state_nxt = start ? SHIFT : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Conversion datapath: load operands, then correct-and-shift once per cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh_bin <= '0;
         bcd    <= '0;
         cnt    <= '0;
      end else if (load) begin
         sh_bin <= bin_in;
         bcd    <= '0;
         cnt    <= CNT_W'(IN_W);
      end else if (state == SHIFT) begin
         sh_bin <= sh_bin << 1;
         bcd    <= bcd_shift;
         cnt    <= cnt - CNT_W'(1);
      end
   end

   // Registered outputs; results are captured on the final shift so they are valid with done.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy   <= 1'b0;
         done   <= 1'b0;
         digits <= '0;
         blank  <= BLANK_RST;
      end else begin
         busy <= (state_nxt != IDLE);
         done <= last;
         if (last) begin
            digits <= bcd_shift;
            blank  <= blank_nxt;
         end
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: stimulus pushes expected results, a monitor checks each done.
// Latency: expects done IN_W edges after acceptance.
// Backpressure: stimulus only issues starts when busy is low, except deliberate ignored/held cases.
module tb_bin_to_bcd_seq;

   localparam int IN_W   = 16;
   localparam int DIGITS = 5;

   typedef struct {
      int unsigned val;
      int          acc;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [IN_W-1:0]   bin_in;
   logic              busy;
   logic              done;
   logic [4*DIGITS-1:0] digits;
   logic [DIGITS-1:0] blank;

   int   ntests = 0;
   int   nfail  = 0;
   int   cyc    = 0;
   int   done_cnt = 0;
   logic prev_done = 1'b0;
   exp_t q[$];

   bin_to_bcd_seq #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .bin_in (bin_in),
      .busy   (busy),
      .done   (done),
      .digits (digits),
      .blank  (blank)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: decimal digits by division, blank by magnitude comparison.
   function automatic logic [4*DIGITS-1:0] ref_digits(input int unsigned v);
      logic [4*DIGITS-1:0] d;
      int unsigned p;
      d = '0;
      p = 1;
      for (int i = 0; i < DIGITS; i++) begin
         d[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return d;
   endfunction

   function automatic logic [DIGITS-1:0] ref_blank(input int unsigned v);
      logic [DIGITS-1:0] b;
      int unsigned p;
      b = '0;
      p = 10;
      for (int i = 1; i < DIGITS; i++) begin
         b[i] = (v < p);
         p = p * 10;
      end
      return b;
   endfunction

   // Monitor: every done must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset) begin
         if (done) begin
            exp_t e;
            done_cnt++;
            check("done_width", 64'(prev_done), 64'd0);
            if (q.size() == 0) begin
               check("spurious_done", 64'(done), 64'd0);
            end else begin
               e = q.pop_front();
               check("digits", 64'(digits), 64'(ref_digits(e.val)));
               check("blank", 64'(blank), 64'(ref_blank(e.val)));
               check("latency", 64'(cyc - e.acc), 64'(IN_W));
            end
         end
         prev_done = done;
      end else begin
         prev_done = 1'b0;
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busy) check("wait_idle_timeout", 64'(busy), 64'd0);
   endtask

   task automatic convert(input int unsigned v);
      wait_idle();
      start  = 1'b1;
      bin_in = IN_W'(v);
      q.push_back('{v, cyc + 1});
      @(negedge clk);
      start  = 1'b0;
      bin_in = IN_W'($urandom);
   endtask

   initial begin
      int dc;
      int a;
      reset  = 1'b1;
      start  = 1'b0;
      bin_in = '0;
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_digits", 64'(digits), 64'd0);
      check("rst_blank", 64'(blank), 64'b11110);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Directed values, including both range extremes.
      convert(0);
      wait_idle();
      convert(65535);
      convert(1234);
      convert(9);
      wait_idle();

      // Start pulsed mid-conversion is ignored.
      dc = done_cnt;
      convert(500);
      repeat (3) @(negedge clk);
      start  = 1'b1;
      bin_in = IN_W'(42);
      @(negedge clk);
      start  = 1'b0;
      wait_idle();
      check("ignored_start_one_done", 64'(done_cnt - dc), 64'd1);

      // Asynchronous reset mid-conversion discards the result.
      convert(777);
      repeat (7) @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_done", 64'(done), 64'd0);
      check("arst_digits", 64'(digits), 64'd0);
      check("arst_blank", 64'(blank), 64'b11110);
      q.delete();
      dc = done_cnt;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (25) @(negedge clk);
      check("arst_no_done", 64'(done_cnt - dc), 64'd0);
      convert(777);
      wait_idle();

      // Start held across two conversions: done pulses IN_W+1 apart.
      start  = 1'b1;
      bin_in = IN_W'(100);
      a = cyc + 1;
      q.push_back('{100, a});
      q.push_back('{200, a + IN_W + 1});
      @(negedge clk);
      bin_in = IN_W'(200);
      repeat (IN_W + 1) @(negedge clk);
      start = 1'b0;
      dc = done_cnt;
      wait_idle();
      check("b2b_second_done", 64'(done_cnt - dc), 64'd1);

      // Random sweep.
      for (int i = 0; i < 1000; i++) convert($urandom_range(0, 65535));
      wait_idle();
      repeat (2) @(negedge clk);
      check("queue_drained", 64'(q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
